down_counter_seq: RTL and testbench
===================================

# down_counter_seq

Loadable down-counter with borrow output and a small run/done sequencer. It counts in the opposite direction to the team's up-counter family, and it produces the terminal-count and handshake signals that controller FSMs use to time fixed-length loops. Free decrement with wrap and borrow is available when the counter is idle. A loaded count runs to zero under `cnt` and signals `done`.

## Interface
- `WIDTH`, default 3: counter width in bits.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear.
- `ld` in 1: load request.
- `ld_val` in WIDTH: value captured on an accepted load.
- `cnt` in 1: decrement enable.
- `result` out WIDTH: current count (registered).
- `Bo` out 1: registered borrow of the last decrement.
- `zero` out 1: combinational, `result == 0`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse in DONE.

## Operation
- States:
  - IDLE: holds the count; free decrement is allowed.
  - RUN: counting down toward zero.
  - DONE: one-cycle terminal state.
- Priority each edge: `rst` low > `clr` > `ld` > `cnt`.
- `rst` low (async):
  - `result`=0, `Bo`=0, state=IDLE.
  - Hence `busy`=0, `done`=0, `zero`=1.
- `clr`:
  - `result`=0, `Bo`=0, state=IDLE from any state.
  - Aborts a RUN without asserting `done`.
- `ld` in IDLE or DONE:
  - `result`=`ld_val`, `Bo`=0.
  - If `ld_val`≠0, next state is RUN; otherwise next state is DONE.
- `ld` in RUN: ignored, with no effect on count or state.
- `cnt` in IDLE:
  - `{Bo,result}` = `{1'b0,result}` − 1, modulo 2^(WIDTH+1).
  - `Bo`=1 only on the wrap 0→2^WIDTH−1; otherwise 0.
- `cnt` in RUN:
  - `result` decrements by 1 and `Bo`=0.
  - If the pre-decrement value is 1, next state is DONE.
  - No wrap is possible in RUN.
- `cnt` low: `result` and `Bo` hold; `Bo` updates only on a decrement, clear, load, or reset.
- DONE:
  - Always lasts exactly one cycle; `cnt` is ignored.
  - Next state is IDLE unless `ld` is accepted, which gives back-to-back runs.
- `busy` = (state==RUN).
- `done` = (state==DONE).

## Timing
- The load is visible on `result` the cycle after the `ld` edge.
- With N = `ld_val` > 0:
  - `done` is high in the cycle after the edge that samples the N-th `cnt` in RUN.
  - In that cycle, `result`=0 and `zero`=1.
- With `ld_val`=0: `done` pulses the cycle after `ld`; `busy` never asserts.
- Gaps in `cnt` stretch RUN; there is no timeout.
- `clr` and `ld` in the same cycle: `clr` wins, and the load is lost.
- `ld` and `cnt` in the same cycle in IDLE: the load wins, and the decrement is lost.
- Reset deasserting mid-run: the block restarts in IDLE with `result`=0, and no `done` is produced.

## Structure
- Package `counter_pkg`:
  - State enum `cnt_state_t` {IDLE, RUN, DONE}.
  - Default width constant `CNT_WIDTH`=3.
- Sub-module `down_counter_core`: the datapath register and borrow logic.
  - Inputs: `clr`, `load`, `dec`, `ld_val`.
  - Outputs: `result`, `Bo`.
- The top level holds the FSM and gates `load`/`dec` by state.

## Test plan
- Reset low mid-RUN (`result`=5) → immediately `result`=0, `Bo`=0, `busy`=0, `done`=0, `zero`=1.
- IDLE, `result`=0, one `cnt` → `result`=7, `Bo`=1. Next `cnt` → `result`=6, `Bo`=0. `cnt` low → both hold.
- `ld` with `ld_val`=3, then `cnt` held high:
  - `busy` is high for 3 cycles.
  - `result` steps 3→2→1→0.
  - `done` is high for exactly one cycle with `result`=0, then the block is back in IDLE.
- `ld` with `ld_val`=0 → `done` pulses the next cycle, `busy` stays 0.
- In RUN with `result`=2:
  - `ld` with `ld_val`=6 is ignored and `result` stays 2.
  - `clr` then gives `result`=0, IDLE, and no `done`.
- `ld` with `ld_val`=4 asserted in the DONE cycle → next cycle `result`=4, `busy`=1, and no IDLE cycle in between.

Source files
------------

// File: rtl/down_counter_seq_pkg.sv
// rtl/down_counter_seq_pkg.sv - shared types and defaults for the down-counter sequencer
package counter_pkg;

   localparam int CNT_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cnt_state_t;

endpackage

// File: rtl/down_counter_seq_if.sv
// rtl/down_counter_seq_if.sv - control and status bundle of the down-counter sequencer
interface down_counter_seq_if
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
);

   logic             clr;
   logic             ld;
   logic [WIDTH-1:0] ld_val;
   logic             cnt;
   logic [WIDTH-1:0] result;
   logic             Bo;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output clr, ld, ld_val, cnt,
      input  result, Bo, zero, busy, done
   );

   modport slave (
      input  clr, ld, ld_val, cnt,
      output result, Bo, zero, busy, done
   );

endinterface

// File: rtl/down_counter_core.sv
// rtl/down_counter_core.sv - count register with load, clear and borrowing decrement
module down_counter_core
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] result,
   output logic             Bo
);

   // Borrow falls out of a one-bit-wider subtraction; it only sets on 0 -> all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
         Bo     <= 1'b0;
      end else if (clr) begin
         result <= '0;
         Bo     <= 1'b0;
      end else if (load) begin
         result <= ld_val;
         Bo     <= 1'b0;
      end else if (dec) begin
         {Bo, result} <= {1'b0, result} - (WIDTH + 1)'(1);
      end
   end

endmodule

// File: rtl/down_counter_seq.sv
// rtl/down_counter_seq.sv - run/done sequencer that gates load and decrement of the core
module down_counter_seq
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   down_counter_seq_if.slave  bus
);

   cnt_state_t       state;
   cnt_state_t       state_nxt;
   logic             load;
   logic             dec;
   logic [WIDTH-1:0] result;
   logic             Bo;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      dec       = 1'b0;
      if (bus.clr) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.ld) begin
                  load      = 1'b1;
                  state_nxt = (bus.ld_val != '0) ? RUN : DONE;
               end else if (bus.cnt) begin
                  dec = 1'b1;
               end
            end
            RUN: begin
               if (bus.cnt) begin
                  dec = 1'b1;
                  if (result == WIDTH'(1)) begin
                     state_nxt = DONE;
                  end
               end
            end
            DONE: begin
               // A load here starts the next run without passing through IDLE.
               if (bus.ld) begin
                  load      = 1'b1;
                  state_nxt = (bus.ld_val != '0) ? RUN : DONE;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   down_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.clr),
      .load   (load),
      .dec    (dec),
      .ld_val (bus.ld_val),
      .result (result),
      .Bo     (Bo)
   );

   assign bus.result = result;
   assign bus.Bo     = Bo;
   assign bus.zero   = (result == '0);
   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_down_counter_seq.sv
// tb/tb_down_counter_seq.sv - directed self-checking bench for down_counter_seq
module tb_down_counter_seq;

   localparam int WIDTH = 3;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   down_counter_seq_if #(.WIDTH(WIDTH)) bus ();

   down_counter_seq #(
      .WIDTH (WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] r, input logic b,
                            input logic z, input logic bz, input logic d);
      check({tag, ".result"}, 8'(bus.result), r);
      check({tag, ".Bo"},     8'(bus.Bo),     8'(b));
      check({tag, ".zero"},   8'(bus.zero),   8'(z));
      check({tag, ".busy"},   8'(bus.busy),   8'(bz));
      check({tag, ".done"},   8'(bus.done),   8'(d));
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst        = 1'b0;
      bus.clr    = 1'b0;
      bus.ld     = 1'b0;
      bus.ld_val = '0;
      bus.cnt    = 1'b0;
      #2;
      check_all("reset", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // free decrement in IDLE: wrap with borrow, then plain step, then hold
      bus.cnt = 1'b1;
      tick();
      check_all("wrap", 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_all("dec6", 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.cnt = 1'b0;
      tick();
      check_all("hold", 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);

      // load 3 then run to zero
      bus.ld = 1'b1; bus.ld_val = 3'd3;
      tick();
      check_all("ld3", 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.ld = 1'b0; bus.cnt = 1'b1;
      tick();
      check_all("run2", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_all("run1", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_all("done3", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.cnt = 1'b0;
      tick();
      check_all("idle3", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // load zero goes straight to DONE
      bus.ld = 1'b1; bus.ld_val = 3'd0;
      tick();
      check_all("ld0", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.ld = 1'b0;
      tick();
      check_all("ld0_idle", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // load ignored in RUN, clr aborts without done
      bus.ld = 1'b1; bus.ld_val = 3'd5;
      tick();
      bus.ld = 1'b0; bus.cnt = 1'b1;
      tick();
      tick();
      tick();
      bus.cnt = 1'b0;
      check_all("run_at2", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.ld = 1'b1; bus.ld_val = 3'd6;
      tick();
      check_all("ld_in_run", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.ld = 1'b0; bus.clr = 1'b1;
      tick();
      check_all("clr_abort", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.clr = 1'b0;
      tick();
      check_all("clr_nodone", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // back-to-back run: load in the DONE cycle
      bus.ld = 1'b1; bus.ld_val = 3'd1;
      tick();
      bus.ld = 1'b0; bus.cnt = 1'b1;
      tick();
      check_all("done1", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.cnt = 1'b0; bus.ld = 1'b1; bus.ld_val = 3'd4;
      tick();
      check_all("b2b", 8'd4, 1'b0, 1'b0, 1'b1, 1'b0);

      // clr and ld together: clr wins
      bus.clr = 1'b1; bus.ld_val = 3'd3;
      tick();
      check_all("clr_ld", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.clr = 1'b0;

      // ld and cnt together in IDLE: load wins
      bus.ld_val = 3'd2; bus.cnt = 1'b1;
      tick();
      check_all("ld_cnt", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.ld = 1'b0; bus.cnt = 1'b0;
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;

      // asynchronous reset mid-run at 5
      bus.ld = 1'b1; bus.ld_val = 3'd5;
      tick();
      bus.ld = 1'b0;
      check_all("pre_rst", 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_all("async_rst", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check_all("post_rst", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
